// File: rtl/level_map_renderer.sv
// Map-window pixel renderer: side/top walls plus a BCD level number overlay that
// flashes after every level change. Two-stage pixel pipeline, serial double-dabble.
module level_map_renderer #(
  parameter int unsigned PIXEL_WIDTH  = 12,
  parameter int unsigned PHY_WIDTH    = 16,
  parameter int unsigned CAMERA_WIDTH = 6,
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned SCALE_SHIFT  = 3,
  parameter int unsigned WALL_WIDTH   = 10,
  parameter int unsigned WALL_HEIGHT  = 20,
  parameter int unsigned MAP_WIDTH_X  = 480,
  parameter int unsigned DIGIT_X0     = 120,
  parameter int unsigned DIGIT_PITCH  = 120,
  parameter int unsigned DIGIT_Y      = 160,
  parameter int unsigned FLASH_FRAMES = 32,
  parameter logic [PIXEL_WIDTH-1:0] MAP_COLOR   = 12'hFD8,
  parameter logic [PIXEL_WIDTH-1:0] DIGIT_COLOR = 12'h5FF,
  parameter logic [PIXEL_WIDTH-1:0] FLASH_COLOR = 12'hF00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    pixel_valid,
  input  logic [PHY_WIDTH-1:0]    map_x,
  input  logic [PHY_WIDTH-1:0]    map_y,
  input  logic [PHY_WIDTH-1:0]    camera_offset,
  input  logic [CAMERA_WIDTH-1:0] camera_y,
  input  logic                    map_on,
  input  logic [PIXEL_WIDTH-1:0]  background_rgb,
  output logic [PIXEL_WIDTH-1:0]  rgb,
  output logic                    rgb_valid,
  output logic                    level_flash
);

  localparam int unsigned LevelW = CAMERA_WIDTH + 1;
  localparam int unsigned BcdW   = 4 * NUM_DIGITS;
  localparam int unsigned CntW   = $clog2(FLASH_FRAMES + 1);
  localparam int unsigned StepW  = $clog2(LevelW + 1);

  typedef logic [PHY_WIDTH-1:0] coord_t;
  localparam coord_t WallW     = coord_t'(WALL_WIDTH);
  localparam coord_t WallXHi   = coord_t'(MAP_WIDTH_X - WALL_WIDTH);
  localparam coord_t WallH     = coord_t'(WALL_HEIGHT);
  localparam coord_t GlyphSize = coord_t'(10 << SCALE_SHIFT);
  localparam coord_t DigitY    = coord_t'(DIGIT_Y);

  typedef enum logic [1:0] {StIdle, StConvert, StFlash} state_e;

  // Seven-segment style 10x10 font; bit index equals glyph column.
  function automatic logic [9:0] font_row(input logic [3:0] d, input logic [3:0] r);
    logic [6:0] s;  // {a,b,c,d,e,f,g}
    logic [9:0] h, lft, rgt;
    h   = 10'b0011111000;
    lft = 10'b0000001000;
    rgt = 10'b0010000000;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    font_row = '0;
    if (r == 4'd1) begin
      font_row = (s[6] ? h : '0) | (s[1] ? lft : '0) | (s[5] ? rgt : '0);
    end else if (r >= 4'd2 && r <= 4'd4) begin
      font_row = (s[1] ? lft : '0) | (s[5] ? rgt : '0);
    end else if (r == 4'd5) begin
      font_row = (s[0] ? h : '0) | ((s[1] & s[2]) ? lft : '0) | ((s[5] & s[4]) ? rgt : '0);
    end else if (r >= 4'd6 && r <= 4'd8) begin
      font_row = (s[2] ? lft : '0) | (s[4] ? rgt : '0);
    end else if (r == 4'd9) begin
      font_row = (s[3] ? h : '0) | (s[2] ? lft : '0) | (s[4] ? rgt : '0);
    end
  endfunction

  // Control FSM and level/BCD state
  state_e              state_q, state_d;
  logic [LevelW-1:0]   level_q, level_d, sample_q, sample_d, conv_bin_q, conv_bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d, conv_bcd_q, conv_bcd_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [CntW-1:0]     flash_cnt_q, flash_cnt_d;
  logic                level_flash_q, level_flash_d;
  logic [LevelW-1:0]   level_sample;
  logic [BcdW-1:0]     bcd_adj;
  logic [BcdW+LevelW-1:0] dd;

  always_comb begin
    level_sample = {1'b0, camera_y} + LevelW'(1);
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      bcd_adj[4*j +: 4] = (conv_bcd_q[4*j +: 4] >= 4'd5) ? conv_bcd_q[4*j +: 4] + 4'd3
                                                         : conv_bcd_q[4*j +: 4];
    end
    dd            = {bcd_adj, conv_bin_q} << 1;
    state_d       = state_q;
    level_d       = level_q;
    sample_d      = sample_q;
    conv_bin_d    = conv_bin_q;
    conv_bcd_d    = conv_bcd_q;
    bcd_d         = bcd_q;
    step_d        = step_q;
    flash_cnt_d   = flash_cnt_q;
    unique case (state_q)
      StIdle, StFlash: begin
        if (frame_start) begin
          if (level_sample != level_q) begin
            state_d    = StConvert;
            sample_d   = level_sample;
            conv_bin_d = level_sample;
            conv_bcd_d = '0;
            step_d     = '0;
          end else if (state_q == StFlash) begin
            flash_cnt_d = flash_cnt_q - CntW'(1);
            if (flash_cnt_q == CntW'(1)) state_d = StIdle;
          end
        end
      end
      StConvert: begin
        conv_bcd_d = dd[BcdW+LevelW-1:LevelW];
        conv_bin_d = dd[LevelW-1:0];
        step_d     = step_q + StepW'(1);
        if (step_q == StepW'(LevelW - 1)) begin
          bcd_d       = dd[BcdW+LevelW-1:LevelW];
          level_d     = sample_q;
          flash_cnt_d = CntW'(FLASH_FRAMES);
          state_d     = StFlash;
        end
      end
      default: state_d = StIdle;
    endcase
    level_flash_d = (state_d == StFlash);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      level_q       <= '0;
      sample_q      <= '0;
      conv_bin_q    <= '0;
      conv_bcd_q    <= '0;
      bcd_q         <= '0;
      step_q        <= '0;
      flash_cnt_q   <= '0;
      level_flash_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      sample_q      <= sample_d;
      conv_bin_q    <= conv_bin_d;
      conv_bcd_q    <= conv_bcd_d;
      bcd_q         <= bcd_d;
      step_q        <= step_d;
      flash_cnt_q   <= flash_cnt_d;
      level_flash_q <= level_flash_d;
    end
  end

  assign level_flash = level_flash_q;

  // Pixel pipeline stage 1: geometry only
  logic                   s1_valid_q, s1_wall_q, s1_hit_q, s1_on_q;
  logic [1:0]             s1_idx_q, s1_idx_d;
  logic [3:0]             s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic [PIXEL_WIDTH-1:0] s1_bg_q;
  logic                   wall_d, hit_d, in_y;
  coord_t                 y_scrolled, dy, left;

  always_comb begin
    y_scrolled = map_y + camera_offset;
    wall_d     = (map_x < WallW) || (map_x >= WallXHi) || (y_scrolled < WallH);
    dy         = map_y - DigitY;
    in_y       = (map_y >= DigitY) && (dy < GlyphSize);
    s1_row_d   = 4'(dy >> SCALE_SHIFT);
    hit_d      = 1'b0;
    s1_idx_d   = '0;
    s1_col_d   = '0;
    left       = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      left = coord_t'(DIGIT_X0 + k * DIGIT_PITCH);
      if (!hit_d && in_y && (map_x >= left) && ((map_x - left) < GlyphSize)) begin
        hit_d    = 1'b1;
        s1_idx_d = 2'(k);
        s1_col_d = 4'((map_x - left) >> SCALE_SHIFT);
      end
    end
  end

  // Stage 2: font lookup and colour priority
  logic [PIXEL_WIDTH-1:0] rgb_q, rgb_d;
  logic                   rgb_valid_q;
  logic [3:0]             nib;
  logic [NUM_DIGITS-1:0]  blank;
  logic                   lead, sel_blank, glyph_bit;
  logic [9:0]             font_bits;

  always_comb begin
    lead      = 1'b1;
    nib       = '0;
    sel_blank = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      lead     = lead && (bcd_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      blank[k] = lead && (k != NUM_DIGITS - 1);
      if (2'(k) == s1_idx_q) begin
        nib       = bcd_q[4*(NUM_DIGITS-1-k) +: 4];
        sel_blank = blank[k];
      end
    end
    font_bits = font_row(nib, s1_row_q);
    glyph_bit = (s1_col_q < 4'd10) ? font_bits[s1_col_q] : 1'b0;
    if (!s1_on_q) begin
      rgb_d = '1;
    end else if (s1_wall_q) begin
      rgb_d = s1_bg_q;
    end else if (s1_hit_q && glyph_bit && !sel_blank) begin
      rgb_d = (state_q == StFlash && flash_cnt_q[2]) ? FLASH_COLOR : DIGIT_COLOR;
    end else begin
      rgb_d = MAP_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_wall_q   <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_on_q     <= 1'b0;
      s1_idx_q    <= '0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_bg_q     <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= pixel_valid;
      s1_wall_q   <= wall_d;
      s1_hit_q    <= hit_d;
      s1_on_q     <= map_on;
      s1_idx_q    <= s1_idx_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s1_bg_q     <= background_rgb;
      rgb_q       <= rgb_d;
      rgb_valid_q <= s1_valid_q;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_level_map_renderer.sv
// Directed bench for level_map_renderer: walls, digit glyphs, level FSM timing,
// flash colour and reset abort, with hand-computed expected values.
module tb_level_map_renderer;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        pixel_valid;
  logic [15:0] map_x, map_y, camera_offset;
  logic [5:0]  camera_y;
  logic        map_on;
  logic [11:0] background_rgb;
  logic [11:0] rgb;
  logic        rgb_valid;
  logic        level_flash;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [11:0] CMap   = 12'hFD8;
  localparam logic [11:0] CDigit = 12'h5FF;
  localparam logic [11:0] CFlash = 12'hF00;

  level_map_renderer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .pixel_valid    (pixel_valid),
    .map_x          (map_x),
    .map_y          (map_y),
    .camera_offset  (camera_offset),
    .camera_y       (camera_y),
    .map_on         (map_on),
    .background_rgb (background_rgb),
    .rgb            (rgb),
    .rgb_valid      (rgb_valid),
    .level_flash    (level_flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  // Called right after pulse(); counts cycles until level_flash rises.
  task automatic wait_flash(input string tag, input int exp_n);
    int n;
    n = 0;
    while (level_flash !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, n, exp_n);
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic on,
                     input logic [11:0] bg, input logic [11:0] exp);
    @(negedge clk);
    map_x          = 16'(x);
    map_y          = 16'(y);
    map_on         = on;
    background_rgb = bg;
    pixel_valid    = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
    check_val({tag, "_lat1"}, rgb_valid, 1'b0);
    @(negedge clk);
    check_val({tag, "_rgb"}, rgb, exp);
    check_val({tag, "_vld"}, rgb_valid, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b1;
    map_x = 16'd0; map_y = 16'd0; camera_offset = 16'd0; camera_y = 6'd0;
    map_on = 1'b1; background_rgb = 12'h000;
    repeat (3) @(negedge clk);
    check_val("rst_rgb", rgb, 12'h000);
    check_val("rst_vld", rgb_valid, 1'b0);
    check_val("rst_flash", level_flash, 1'b0);
    pixel_valid = 1'b0;
    rst_n = 1'b1;

    // Reset display is "0" with the leading digit blanked
    pix("rst_ls0", 264, 168, 1'b1, 12'h000, CDigit);
    pix("rst_ms_blank", 144, 168, 1'b1, 12'h000, CMap);

    // Walls and map window
    pix("wall_left", 5, 300, 1'b1, 12'h123, 12'h123);
    pix("map_off", 5, 300, 1'b0, 12'h123, 12'hFFF);
    pix("wall_right", 470, 300, 1'b1, 12'h456, 12'h456);
    pix("inside_right", 469, 300, 1'b1, 12'h456, CMap);
    pix("wall_x9", 9, 300, 1'b1, 12'h456, 12'h456);
    pix("inside_x10", 10, 300, 1'b1, 12'h456, CMap);
    pix("wall_top", 100, 19, 1'b1, 12'h789, 12'h789);
    pix("below_top", 100, 20, 1'b1, 12'h789, CMap);
    camera_offset = 16'd10;
    pix("wall_wrap", 100, 65530, 1'b1, 12'hABC, 12'hABC);
    camera_offset = 16'd0;

    // Level 1: conversion timing, blanking, flash colour, 32-frame flash
    camera_y = 6'd0;
    pulse();
    wait_flash("rise_l1", 7);
    pix("l1_ms_blank", 144, 168, 1'b1, 12'h000, CMap);
    pix("l1_ls", 264, 168, 1'b1, 12'h000, CDigit);
    pulse();
    pix("l1_flash_red", 264, 168, 1'b1, 12'h000, CFlash);
    frames(30);
    check_val("l1_hold31", level_flash, 1'b1);
    pix("l1_cnt1_col", 264, 168, 1'b1, 12'h000, CDigit);
    pulse();
    check_val("l1_fall32", level_flash, 1'b0);

    // Level 12 glyph bits
    camera_y = 6'd11;
    pulse();
    wait_flash("rise_l12", 7);
    frames(32);
    check_val("l12_fall", level_flash, 1'b0);
    pix("l12_one_c3", 144, 168, 1'b1, 12'h000, CDigit);
    pix("l12_one_c0", 120, 168, 1'b1, 12'h000, CMap);
    pix("l12_two_c5", 280, 168, 1'b1, 12'h000, CDigit);
    pix("l12_two_r6", 264, 208, 1'b1, 12'h000, CDigit);

    // Level change mid-flash restarts conversion and reloads the counter
    camera_y = 6'd4;
    pulse();
    wait_flash("rise_l5", 7);
    frames(22);
    pix("l5_r6_clear", 264, 208, 1'b1, 12'h000, CMap);
    camera_y = 6'd5;
    pulse();
    check_val("restart_conv", level_flash, 1'b0);
    wait_flash("rise_l6", 7);
    pix("l6_r6_set", 264, 208, 1'b1, 12'h000, CDigit);
    pulse();
    pix("l6_reload_red", 264, 208, 1'b1, 12'h000, CFlash);
    frames(30);
    check_val("l6_hold", level_flash, 1'b1);
    pulse();
    check_val("l6_fall", level_flash, 1'b0);

    // Maximum level "64"
    camera_y = 6'd63;
    pulse();
    wait_flash("rise_l64", 7);
    pix("l64_six_r6", 144, 208, 1'b1, 12'h000, CDigit);
    pix("l64_four_r5", 280, 200, 1'b1, 12'h000, CDigit);
    pix("l64_four_r1", 280, 168, 1'b1, 12'h000, CMap);
    frames(32);

    // Input changed during conversion: old sample latched, next frame re-converts
    camera_y = 6'd20;
    pulse();
    camera_y = 6'd30;
    wait_flash("rise_l21", 7);
    pix("old_sample", 144, 208, 1'b1, 12'h000, CDigit);
    pulse();
    check_val("resample", level_flash, 1'b0);
    wait_flash("rise_l31", 7);
    pix("new_sample", 144, 208, 1'b1, 12'h000, CMap);

    // Reset in the middle of a conversion
    camera_y = 6'd40;
    pulse();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_rgb", rgb, 12'h000);
    check_val("abort_vld", rgb_valid, 1'b0);
    check_val("abort_flash", level_flash, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_val("abort_no_flash", level_flash, 1'b0);
    pix("abort_ls0", 264, 168, 1'b1, 12'h000, CDigit);
    pix("abort_ms_blank", 144, 168, 1'b1, 12'h000, CMap);
    pulse();
    wait_flash("abort_resample", 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
